out_arbiter: RTL and testbench

Downstream consumer of the per-input-port flit FIFOs: one instance per router output port. It arbitrates round-robin among NPort input buffers, pops flits with each buffer's read_en/buf_out protocol, and holds the grant from head flit to tail flit (wormhole). Accepted flits pass through a 2-entry output queue with a valid/ready handshake toward the link or crossbar.

---
 rtl/out_arbiter.sv | 178 +++++++++++++++++
 tb/tb_out_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : out_arbiter
// Description : Wormhole round-robin arbiter that pops flits from NPort input
//               FIFOs into a 2-entry valid/ready output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module out_arbiter #(
    parameter int DASize = 10,
    parameter int NPort  = 4,
    parameter int PSize  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPort*DASize-1:0] buf_out,
    input  logic [NPort-1:0]        buf_empty,
    input  logic [NPort-1:0]        buf_full,
    input  logic [NPort-1:0]        buf_wr,
    output logic [NPort-1:0]        read_en,
    output logic [DASize-1:0]       out_flit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PSize-1:0]        out_gnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PSize-1:0]   gnt_q, gnt_d;
    logic [PSize-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DASize-1:0]  mem_q [2];
    logic [DASize-1:0]  mem_d [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         occ_q, occ_d;

    logic [DASize-1:0]  w_slice [NPort];
    logic [NPort-1:0]   w_elig;
    logic               w_any;
    logic               w_pop;
    logic               w_land;
    logic [2:0]         w_need;
    logic               w_space;
    logic [DASize-1:0]  w_landed;
    logic               w_is_tail;
    logic [PSize-1:0]   w_next_gnt;
    logic [PSize-1:0]   w_pick_rr;
    logic [PSize-1:0]   w_pick_next;
    logic               w_push;

    // First requester at or after start, wrapping modulo NPort.
    function automatic logic [PSize-1:0] rr_pick(input logic [NPort-1:0] req,
                                                 input logic [PSize-1:0] start);
        logic [PSize-1:0] idx;
        rr_pick = start;
        for (int k = NPort - 1; k >= 0; k--) begin
            idx = start + PSize'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    for (genvar i = 0; i < NPort; i++) begin : g_slice
        assign w_slice[i] = buf_out[i*DASize +: DASize];
    end

    // A FIFO drops a read that coincides with an accepted write.
    assign w_elig      = ~buf_empty & ~(buf_wr & ~buf_full);
    assign w_any       = |w_elig;
    assign out_valid   = (occ_q != 2'd0);
    assign w_pop       = out_valid & out_ready;
    assign w_land      = (state_q == ST_FETCH);
    assign w_need      = {1'b0, occ_q} + {2'b00, w_land} - {2'b00, w_pop};
    assign w_space     = (w_need <= 3'd1);
    assign w_landed    = w_slice[gnt_q];
    assign w_is_tail   = w_landed[DASize-1];
    assign w_next_gnt  = gnt_q + PSize'(1);
    assign w_pick_rr   = rr_pick(w_elig, rr_ptr_q);
    assign w_pick_next = rr_pick(w_elig, w_next_gnt);

    assign out_flit    = mem_q[rd_ptr_q];
    assign out_gnt     = gnt_q;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        read_en  = '0;
        w_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_space && w_any) begin
                    read_en[w_pick_rr] = 1'b1;
                    gnt_d              = w_pick_rr;
                    state_d            = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_push = 1'b1;
                if (w_is_tail) begin
                    rr_ptr_d = w_next_gnt;
                    if (w_space && w_any) begin
                        read_en[w_pick_next] = 1'b1;
                        gnt_d                = w_pick_next;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (w_elig[gnt_q] && w_space) begin
                    read_en[gnt_q] = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_elig[gnt_q] && w_space) begin
                    read_en[gnt_q] = 1'b1;
                    state_d        = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A pop issued during reset would be lost, so suppress it.
        if (rst) begin
            read_en = '0;
        end
    end

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_landed;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_out_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_arbiter
// Description : Directed self-checking bench for out_arbiter with FIFO models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_arbiter;

    localparam int DW = 10;
    localparam int NP = 4;
    localparam int PW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NP*DW-1:0] buf_out;
    logic [NP-1:0]    buf_empty;
    logic [NP-1:0]    buf_full;
    logic [NP-1:0]    buf_wr;
    logic [NP-1:0]    read_en;
    logic [DW-1:0]    out_flit;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_gnt;

    always #5 clk = ~clk;

    out_arbiter #(.DASize(DW), .NPort(NP), .PSize(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_out   (buf_out),
        .buf_empty (buf_empty),
        .buf_full  (buf_full),
        .buf_wr    (buf_wr),
        .read_en   (read_en),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gnt   (out_gnt)
    );

    logic [DW-1:0] fmem [NP][32];
    int            wp [NP];
    int            rp [NP];
    logic [DW-1:0] wdata [NP];

    int            cyc;
    int            n_pass;
    int            n_total;
    int            viol;
    int            rd_cyc [$];
    logic [NP-1:0] rd_val [$];
    logic [DW-1:0] rx_flit [$];
    int            rx_cyc [$];

    task automatic load(input int p, input logic [DW-1:0] f);
        fmem[p][wp[p] % 32] = f;
        wp[p]++;
        buf_empty[p] = 1'b0;
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        rd_val.delete();
        rx_flit.delete();
        rx_cyc.delete();
    endtask

    // Sample at negedge, then advance the FIFO models just after posedge.
    task automatic tick();
        logic [NP-1:0] rd_s;
        logic [NP-1:0] wr_s;
        logic [NP-1:0] elig;
        logic [DW-1:0] d;
        @(negedge clk);
        wr_s = buf_wr & ~buf_full;
        elig = ~buf_empty & ~wr_s;
        rd_s = read_en;
        if (rd_s != '0) begin
            rd_cyc.push_back(cyc);
            rd_val.push_back(rd_s);
        end
        if ($countones(rd_s) > 1 || (rd_s & ~elig) != '0) viol++;
        if (out_valid && out_ready) begin
            rx_flit.push_back(out_flit);
            rx_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NP; i++) begin
            d = '0;
            if (rd_s[i] && !wr_s[i] && wp[i] != rp[i]) begin
                d = fmem[i][rp[i] % 32];
                rp[i]++;
            end
            if (wr_s[i]) begin
                fmem[i][wp[i] % 32] = wdata[i];
                wp[i]++;
            end
            buf_out[i*DW +: DW] = d;
            buf_empty[i] = (wp[i] == rp[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        #1;
        n_total++;
        if (read_en !== 4'b0000) $display("FAIL reset_read_en: got %b, want 0000", read_en); else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, want 0", out_valid); else n_pass++;
        n_total++;
        if (out_flit !== 10'h000) $display("FAIL reset_out_flit: got %h, want 000", out_flit); else n_pass++;
        n_total++;
        if (out_gnt !== 2'd0) $display("FAIL reset_out_gnt: got %0d, want 0", out_gnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int base;
        logic [DW-1:0] ef [3];
        ef = '{10'h100, 10'h0AA, 10'h2BB};
        clear_logs();
        load(1, ef[0]); load(1, ef[1]); load(1, ef[2]);
        base = cyc;
        repeat (8) tick();
        n_total++;
        if (rd_cyc.size() != 3) $display("FAIL single_rd_count: got %0d, want 3", rd_cyc.size()); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (k >= rd_cyc.size()) $display("FAIL single_rd[%0d]: got none, want 0010 at cycle %0d", k, base + k);
            else if (rd_cyc[k] !== base + k || rd_val[k] !== 4'b0010)
                $display("FAIL single_rd[%0d]: got %b at cycle %0d, want 0010 at cycle %0d", k, rd_val[k], rd_cyc[k] - base, k);
            else n_pass++;
        end
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL single_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k] || rx_cyc[k] !== base + 2 + k)
                $display("FAIL single_rx[%0d]: got %h at cycle %0d, want %h at cycle %0d", k, rx_flit[k], rx_cyc[k] - base, ef[k], k + 2);
            else n_pass++;
        end
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL single_idle_valid: got %b, want 0", out_valid); else n_pass++;
    endtask

    task automatic test_contention();
        int base;
        logic [DW-1:0] ef [5];
        logic [NP-1:0] er [5];
        ef = '{10'h301, 10'h302, 10'h303, 10'h304, 10'h305};
        er = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        clear_logs();
        rst = 1'b1;
        load(0, ef[0]); load(1, ef[1]); load(2, ef[2]); load(3, ef[3]); load(0, ef[4]);
        tick();
        rst = 1'b0;
        base = cyc;
        repeat (9) tick();
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (k >= rd_cyc.size()) $display("FAIL cont_rd[%0d]: got none, want %b", k, er[k]);
            else if (rd_cyc[k] !== base + k || rd_val[k] !== er[k])
                $display("FAIL cont_rd[%0d]: got %b at cycle %0d, want %b at cycle %0d", k, rd_val[k], rd_cyc[k] - base, er[k], k);
            else n_pass++;
        end
        n_total++;
        if (rx_flit.size() != 5) $display("FAIL cont_rx_count: got %0d, want 5", rx_flit.size()); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL cont_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k] || rx_cyc[k] !== base + 2 + k)
                $display("FAIL cont_rx[%0d]: got %h at cycle %0d, want %h at cycle %0d", k, rx_flit[k], rx_cyc[k] - base, ef[k], k + 2);
            else n_pass++;
        end
    endtask

    task automatic test_wormhole();
        int base;
        logic [DW-1:0] ef [4];
        int            ec [4];
        logic [NP-1:0] er [4];
        int            erc [4];
        ef  = '{10'h1A0, 10'h0A1, 10'h2A2, 10'h3C2};
        ec  = '{2, 3, 10, 11};
        er  = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
        erc = '{0, 1, 8, 9};
        clear_logs();
        load(0, ef[0]); load(0, ef[1]);
        base = cyc;
        tick();
        load(2, ef[3]);
        repeat (7) tick();
        load(0, ef[2]);
        repeat (6) tick();
        n_total++;
        if (rd_cyc.size() != 4) $display("FAIL worm_rd_count: got %0d, want 4", rd_cyc.size()); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (k >= rd_cyc.size()) $display("FAIL worm_rd[%0d]: got none, want %b", k, er[k]);
            else if (rd_cyc[k] !== base + erc[k] || rd_val[k] !== er[k])
                $display("FAIL worm_rd[%0d]: got %b at cycle %0d, want %b at cycle %0d", k, rd_val[k], rd_cyc[k] - base, er[k], erc[k]);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL worm_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k] || rx_cyc[k] !== base + ec[k])
                $display("FAIL worm_rx[%0d]: got %h at cycle %0d, want %h at cycle %0d", k, rx_flit[k], rx_cyc[k] - base, ef[k], ec[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int base;
        logic [DW-1:0] ef [6];
        ef = '{10'h110, 10'h011, 10'h012, 10'h013, 10'h014, 10'h215};
        clear_logs();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) load(3, ef[k]);
        base = cyc;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k >= 2) begin
                n_total++;
                if (out_valid !== 1'b1 || out_flit !== ef[0])
                    $display("FAIL bp_hold[%0d]: got valid=%b flit=%h, want valid=1 flit=%h", k, out_valid, out_flit, ef[0]);
                else n_pass++;
            end
        end
        n_total++;
        if (rd_cyc.size() != 2) $display("FAIL bp_rd_count: got %0d, want 2", rd_cyc.size()); else n_pass++;
        n_total++;
        if (rx_flit.size() != 0) $display("FAIL bp_rx_stalled: got %0d, want 0", rx_flit.size()); else n_pass++;
        out_ready = 1'b1;
        repeat (12) tick();
        n_total++;
        if (rx_flit.size() != 6) $display("FAIL bp_rx_count: got %0d, want 6", rx_flit.size()); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL bp_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k]) $display("FAIL bp_rx[%0d]: got %h, want %h", k, rx_flit[k], ef[k]);
            else n_pass++;
        end
        if (base < 0) viol++;
    endtask

    task automatic test_collision();
        int base;
        logic [DW-1:0] ef [2];
        ef = '{10'h3D1, 10'h3D4};
        clear_logs();
        load(1, ef[0]);
        buf_wr[1]   = 1'b1;
        buf_full[1] = 1'b0;
        wdata[1]    = ef[1];
        base = cyc;
        tick();
        buf_wr[1] = 1'b0;
        repeat (6) tick();
        n_total++;
        if (rd_cyc.size() != 2) $display("FAIL coll_rd_count: got %0d, want 2", rd_cyc.size()); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (k >= rd_cyc.size()) $display("FAIL coll_rd[%0d]: got none, want 0010", k);
            else if (rd_cyc[k] !== base + 1 + k || rd_val[k] !== 4'b0010)
                $display("FAIL coll_rd[%0d]: got %b at cycle %0d, want 0010 at cycle %0d", k, rd_val[k], rd_cyc[k] - base, k + 1);
            else n_pass++;
        end
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL coll_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k] || rx_cyc[k] !== base + 3 + k)
                $display("FAIL coll_rx[%0d]: got %h at cycle %0d, want %h at cycle %0d", k, rx_flit[k], rx_cyc[k] - base, ef[k], k + 3);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int b2;
        logic [DW-1:0] ef [3];
        logic [NP-1:0] er [3];
        ef = '{10'h3F1, 10'h1F3, 10'h2F4};
        er = '{4'b0010, 4'b1000, 4'b1000};
        clear_logs();
        out_ready = 1'b0;
        load(2, 10'h1E0); load(2, 10'h0E1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b, want 0", out_valid); else n_pass++;
        n_total++;
        if (out_flit !== 10'h000) $display("FAIL rstmid_flit: got %h, want 000", out_flit); else n_pass++;
        n_total++;
        if (out_gnt !== 2'd0) $display("FAIL rstmid_gnt: got %0d, want 0", out_gnt); else n_pass++;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (rd_cyc.size() != 2) $display("FAIL rstmid_rd_count: got %0d, want 2", rd_cyc.size()); else n_pass++;
        clear_logs();
        load(1, ef[0]); load(3, ef[1]); load(3, ef[2]);
        b2 = cyc;
        repeat (7) tick();
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (k >= rd_cyc.size()) $display("FAIL rstmid_rd[%0d]: got none, want %b", k, er[k]);
            else if (rd_cyc[k] !== b2 + k || rd_val[k] !== er[k])
                $display("FAIL rstmid_rd[%0d]: got %b at cycle %0d, want %b at cycle %0d", k, rd_val[k], rd_cyc[k] - b2, er[k], k);
            else n_pass++;
        end
        n_total++;
        if (rx_flit.size() != 3) $display("FAIL rstmid_rx_count: got %0d, want 3", rx_flit.size()); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (k >= rx_flit.size()) $display("FAIL rstmid_rx[%0d]: got none, want %h", k, ef[k]);
            else if (rx_flit[k] !== ef[k] || rx_cyc[k] !== b2 + 2 + k)
                $display("FAIL rstmid_rx[%0d]: got %h at cycle %0d, want %h at cycle %0d", k, rx_flit[k], rx_cyc[k] - b2, ef[k], k + 2);
            else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_total++;
        if (viol != 0) $display("FAIL protocol: got %0d illegal read_en cycles, want 0", viol); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        buf_out   = '0;
        buf_empty = '1;
        buf_full  = '0;
        buf_wr    = '0;
        out_ready = 1'b1;
        cyc       = 0;
        n_pass    = 0;
        n_total   = 0;
        viol      = 0;
        for (int i = 0; i < NP; i++) begin
            wp[i]    = 0;
            rp[i]    = 0;
            wdata[i] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_wormhole();
        test_backpressure();
        test_collision();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
